// File: rtl/iir_biquad_pkg.sv
// Shared definitions for the multi-channel Direct Form I biquad:
// tap indices, sequencer states and arithmetic width/bound helpers.
package iir_biquad_pkg;

  localparam int N_TAPS = 5;

  localparam logic [2:0] TAP_B0 = 3'd0;
  localparam logic [2:0] TAP_B1 = 3'd1;
  localparam logic [2:0] TAP_B2 = 3'd2;
  localparam logic [2:0] TAP_A1 = 3'd3;
  localparam logic [2:0] TAP_A2 = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAC0,
    S_MAC1,
    S_MAC2,
    S_MAC3,
    S_MAC4,
    S_SAT,
    S_DONE
  } state_e;

  // Five W x C products cannot overflow three guard bits.
  function automatic int acc_width(input int w, input int c);
    return w + c + 3;
  endfunction

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/iir_biquad_mc_coef.sv
// Coefficient register file: N_BANK banks of five taps (b0,b1,b2,a1,a2),
// synchronous write, combinational read. Reset loads unity-gain passthrough.
module iir_coef_bank
  import iir_biquad_pkg::*;
#(
  parameter int N_BANK = 4,
  parameter int C      = 25,
  parameter int F      = 16,
  parameter int BW     = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [BW-1:0] wbank_i,
  input  logic [2:0]    wtap_i,
  input  logic [C-1:0]  wdata_i,
  input  logic [BW-1:0] rbank_i,
  input  logic [2:0]    rtap_i,
  output logic [C-1:0]  rdata_o
);

  localparam logic [C-1:0] UNITY = C'(1) << F;

  logic [C-1:0] coef_q [N_BANK][N_TAPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < N_BANK; b++) begin
        for (int t = 0; t < N_TAPS; t++) begin
          coef_q[b][t] <= (t == 0) ? UNITY : '0;
        end
      end
    end else if (we_i && (wtap_i < 3'(N_TAPS)) && (32'(wbank_i) < N_BANK)) begin
      coef_q[wbank_i][wtap_i] <= wdata_i;
    end
  end

  always_comb begin
    rdata_o = '0;
    if ((rtap_i < 3'(N_TAPS)) && (32'(rbank_i) < N_BANK)) begin
      rdata_o = coef_q[rbank_i][rtap_i];
    end
  end

endmodule

// File: rtl/iir_biquad_mc.sv
// Time-multiplexed multi-channel DF-I biquad, one shared multiplier.
// states: IDLE wait rx | MAC0..MAC4 one tap per cycle | SAT shift, clip, history | DONE publish y
module iir_biquad_mc
  import iir_biquad_pkg::*;
#(
  parameter int W      = 25,
  parameter int F      = 16,
  parameter int C      = 25,
  parameter int N_CH   = 2,
  parameter int N_BANK = 4,
  localparam int CHW   = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int BW    = (N_BANK > 1) ? $clog2(N_BANK) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rx,
  input  logic [W-1:0]   u,
  input  logic [CHW-1:0] ch,
  input  logic [BW-1:0]  bank_sel,
  input  logic           coef_we,
  input  logic [BW+2:0]  coef_addr,
  input  logic [C-1:0]   coef_data,
  input  logic           state_clr,
  output logic           rx_2,
  output logic [W-1:0]   y,
  output logic [CHW-1:0] y_ch,
  output logic           busy,
  output logic           overrun,
  output logic           cfg_err
);

  localparam int ACC_W = acc_width(W, C);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(sat_max(W));
  localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(sat_min(W));

  state_e state_q, state_d;

  logic signed [W-1:0]     x_q, res_q, y_q;
  logic [CHW-1:0]          ch_q, y_ch_q;
  logic [BW-1:0]           bank_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [W-1:0]     x1_q [N_CH];
  logic signed [W-1:0]     x2_q [N_CH];
  logic signed [W-1:0]     y1_q [N_CH];
  logic signed [W-1:0]     y2_q [N_CH];
  logic                    rx_2_q, overrun_q, cfg_err_q, clr_pend_q;

  logic [2:0]              tap;
  logic signed [W-1:0]     op;
  logic [C-1:0]            coef_rd;
  logic signed [W+C-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext, acc_shr;
  logic signed [W-1:0]     sat_val;
  logic                    accept, coef_ok, clr_now;
  logic [BW-1:0]           wbank;
  logic [2:0]              wtap;

  assign busy           = (state_q != S_IDLE);
  assign accept         = rx && !busy;
  assign {wbank, wtap}  = coef_addr;
  assign coef_ok        = coef_we && !busy && (wtap <= TAP_A2);
  // A clear requested mid-computation is held until the sequencer is idle again.
  assign clr_now        = !busy && (state_clr || clr_pend_q);

  iir_coef_bank #(
    .N_BANK (N_BANK),
    .C      (C),
    .F      (F),
    .BW     (BW)
  ) u_coef (
    .clk     (clk),
    .rst     (rst),
    .we_i    (coef_ok),
    .wbank_i (wbank),
    .wtap_i  (wtap),
    .wdata_i (coef_data),
    .rbank_i (bank_q),
    .rtap_i  (tap),
    .rdata_o (coef_rd)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    tap     = TAP_B0;
    op      = x_q;
    case (state_q)
      S_IDLE: if (rx) state_d = S_MAC0;
      S_MAC0: state_d = S_MAC1;
      S_MAC1: begin state_d = S_MAC2; tap = TAP_B1; op = x1_q[ch_q]; end
      S_MAC2: begin state_d = S_MAC3; tap = TAP_B2; op = x2_q[ch_q]; end
      S_MAC3: begin state_d = S_MAC4; tap = TAP_A1; op = y1_q[ch_q]; end
      S_MAC4: begin state_d = S_SAT;  tap = TAP_A2; op = y2_q[ch_q]; end
      S_SAT:  state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign prod     = op * $signed(coef_rd);
  assign prod_ext = {{3{prod[W+C-1]}}, prod};
  assign acc_shr  = acc_q >>> F;

  always_comb begin
    sat_val = acc_shr[W-1:0];
    if (acc_shr > SAT_HI)      sat_val = SAT_HI[W-1:0];
    else if (acc_shr < SAT_LO) sat_val = SAT_LO[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q        <= '0;
      ch_q       <= '0;
      bank_q     <= '0;
      acc_q      <= '0;
      res_q      <= '0;
      y_q        <= '0;
      y_ch_q     <= '0;
      rx_2_q     <= 1'b0;
      overrun_q  <= 1'b0;
      cfg_err_q  <= 1'b0;
      clr_pend_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        x1_q[i] <= '0;
        x2_q[i] <= '0;
        y1_q[i] <= '0;
        y2_q[i] <= '0;
      end
    end else begin
      rx_2_q <= 1'b0;
      if (accept) begin
        x_q    <= $signed(u);
        ch_q   <= ch;
        bank_q <= bank_sel;
        acc_q  <= '0;
      end
      if (rx && busy)           overrun_q  <= 1'b1;
      if (coef_we && !coef_ok)  cfg_err_q  <= 1'b1;
      if (busy && state_clr)    clr_pend_q <= 1'b1;
      if (clr_now) begin
        clr_pend_q <= 1'b0;
        for (int i = 0; i < N_CH; i++) begin
          x1_q[i] <= '0;
          x2_q[i] <= '0;
          y1_q[i] <= '0;
          y2_q[i] <= '0;
        end
      end
      case (state_q)
        S_MAC0, S_MAC1, S_MAC2: acc_q <= acc_q + prod_ext;
        S_MAC3, S_MAC4:         acc_q <= acc_q - prod_ext;
        S_SAT: begin
          res_q      <= sat_val;
          x2_q[ch_q] <= x1_q[ch_q];
          x1_q[ch_q] <= x_q;
          y2_q[ch_q] <= y1_q[ch_q];
          y1_q[ch_q] <= sat_val;
        end
        S_DONE: begin
          y_q    <= res_q;
          y_ch_q <= ch_q;
          rx_2_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign rx_2    = rx_2_q;
  assign y       = y_q;
  assign y_ch    = y_ch_q;
  assign overrun = overrun_q;
  assign cfg_err = cfg_err_q;

endmodule
